// File: rtl/mlcd_pkg.sv
// Shared types and constants for the MIPI-style LCD frame sequencer.
// Optional TE-synchronised start is enabled with MLCD_TE_SYNC_EN.
package mlcd_pkg;

    typedef enum logic [2:0] {
        IDLE, SYNC, WIN_X, WIN_Y, GRAM, STREAM, DONE
    } state_e;

    typedef enum logic [1:0] {
        WP_IDLE, WP_LO, WP_HI
    } wr_phase_e;

    typedef struct packed {
        logic        rs;
        logic [15:0] data;
    } bus_word_t;

    localparam logic [7:0]  CMD_X    = 8'h2A;
    localparam logic [7:0]  CMD_Y    = 8'h2B;
    localparam logic [7:0]  CMD_GRAM = 8'h2C;
    localparam logic [15:0] ID_5510  = 16'h5510;

    // Window write sequence: 5510 interleaves 4 cmd/data pairs,
    // other panels send one command then four data words.
    function automatic bus_word_t win_word(
        input logic        is55,
        input logic [7:0]  base,
        input logic [3:0]  step,
        input logic [15:0] last
    );
        bus_word_t  w;
        logic       cmd;
        logic [1:0] idx;
        cmd  = is55 ? ~step[0] : (step == 4'd0);
        idx  = is55 ? step[2:1] : 2'(step - 4'd1);
        w.rs = ~cmd;
        case (idx)
            2'd2:    w.data = {8'h00, last[15:8]};
            2'd3:    w.data = {8'h00, last[7:0]};
            default: w.data = 16'h0000;
        endcase
        if (cmd) begin
            w.data = is55 ? {base, 6'b0, idx} : {8'h00, base};
        end
        return w;
    endfunction

endpackage

// File: rtl/mlcd_wr_cycle.sv
// One 8080-style bus write: wr_n low for WR_LO clocks, high for WR_HI.
// done marks the final high clock so a new write can follow back-to-back.
module mlcd_wr_cycle
    import mlcd_pkg::*;
#(
    parameter int WR_LO = 1,
    parameter int WR_HI = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        start,
    input  logic        rs_in,
    input  logic [15:0] data_in,
    output logic        wr_n,
    output logic        rs_out,
    output logic [15:0] data_out,
    output logic        ready,
    output logic        done
);

    localparam logic [3:0] LO_LAST = 4'(WR_LO - 1);
    localparam logic [3:0] HI_LAST = 4'(WR_HI - 1);

    wr_phase_e   phase_q, phase_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        wr_n_q, wr_n_d;
    logic        rs_q, rs_d;
    logic [15:0] data_q, data_d;

    always_comb begin
        phase_d = phase_q;
        cnt_d   = cnt_q;
        wr_n_d  = wr_n_q;
        rs_d    = rs_q;
        data_d  = data_q;
        done    = (phase_q == WP_HI) && (cnt_q == HI_LAST);
        ready   = (phase_q == WP_IDLE) || done;
        unique case (phase_q)
            WP_LO: begin
                if (cnt_q == LO_LAST) begin
                    phase_d = WP_HI;
                    cnt_d   = 4'd0;
                    wr_n_d  = 1'b1;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            WP_HI: begin
                if (done) begin
                    phase_d = WP_IDLE;
                    cnt_d   = 4'd0;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            default: ;
        endcase
        if (ready && start) begin
            phase_d = WP_LO;
            cnt_d   = 4'd0;
            wr_n_d  = 1'b0;
            rs_d    = rs_in;
            data_d  = data_in;
        end
        if (clr) begin
            phase_d = WP_IDLE;
            cnt_d   = 4'd0;
            wr_n_d  = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            phase_q <= WP_IDLE;
            cnt_q   <= 4'd0;
            wr_n_q  <= 1'b1;
            rs_q    <= 1'b1;
            data_q  <= 16'h0000;
        end else begin
            phase_q <= phase_d;
            cnt_q   <= cnt_d;
            wr_n_q  <= wr_n_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
        end
    end

    assign wr_n     = wr_n_q;
    assign rs_out   = rs_q;
    assign data_out = data_q;

endmodule

// File: rtl/mlcd_frame_seq.sv
// Frame writer: sets the GRAM window, then streams H_RES*V_RES pixels.
// Define MLCD_TE_SYNC_EN to hold SYNC until a tearing-effect rising edge.
module mlcd_frame_seq
    import mlcd_pkg::*;
#(
    parameter int H_RES = 480,
    parameter int V_RES = 800,
    parameter int WR_LO = 1,
    parameter int WR_HI = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        lcd_init_done,
    input  logic [15:0] lcd_id,
    input  logic        frame_start,
    input  logic        lcd_te,
    input  logic [15:0] pixel_data,
    input  logic [8:0]  rdusedw,
    output logic        pixel_en,
    output logic        mlcd_cs_n,
    output logic        mlcd_wr_n,
    output logic        mlcd_rd_n,
    output logic        mlcd_rs,
    output logic [15:0] mlcd_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int NPIX = H_RES * V_RES;
    localparam int PW   = (NPIX > 1) ? $clog2(NPIX) : 1;
    localparam logic [PW-1:0] PIX_LAST = PW'(NPIX - 1);

    state_e        state_q, state_d;
    logic [3:0]    step_q, step_d;
    logic [PW-1:0] pix_q, pix_d;
    logic          last_q, last_d;
    logic          cs_n_q, cs_n_d;
    logic          pix_en_q, pix_en_d;

    logic       is55;
    logic [3:0] n_win;
    bus_word_t  win, gram, wc_word;
    logic       wc_start, wc_clr, wc_ready, wc_done;
    logic       te_rise;

`ifdef MLCD_TE_SYNC_EN
    logic [2:0] te_q, te_d;
    assign te_d    = {te_q[1:0], lcd_te};
    assign te_rise = te_q[1] & ~te_q[2];
    always_ff @(posedge clk) begin
        if (!rst_n) te_q <= 3'b000;
        else        te_q <= te_d;
    end
`else
    logic te_unused;
    assign te_unused = lcd_te;
    assign te_rise   = 1'b1;
`endif

    assign is55  = (lcd_id == ID_5510);
    assign n_win = is55 ? 4'd8 : 4'd5;
    assign win   = win_word(is55,
                            (state_q == WIN_Y) ? CMD_Y : CMD_X,
                            step_q,
                            (state_q == WIN_Y) ? 16'(V_RES - 1)
                                               : 16'(H_RES - 1));
    assign gram.rs   = 1'b0;
    assign gram.data = is55 ? {CMD_GRAM, 8'h00} : {8'h00, CMD_GRAM};

    always_comb begin
        state_d    = state_q;
        step_d     = step_q;
        pix_d      = pix_q;
        last_d     = last_q;
        pix_en_d   = 1'b0;
        wc_start   = 1'b0;
        wc_clr     = 1'b0;
        wc_word.rs   = 1'b1;
        wc_word.data = pixel_data;
        unique case (state_q)
            IDLE: if (frame_start && lcd_init_done) state_d = SYNC;
            SYNC: if (te_rise) state_d = WIN_X;
            WIN_X, WIN_Y: begin
                wc_word = win;
                if (step_q == n_win) begin
                    if (wc_done) begin
                        state_d = (state_q == WIN_X) ? WIN_Y : GRAM;
                        step_d  = 4'd0;
                    end
                end else if (wc_ready) begin
                    wc_start = 1'b1;
                    step_d   = step_q + 4'd1;
                end
            end
            GRAM: begin
                wc_word = gram;
                if (step_q != 4'd0) begin
                    if (wc_done) begin
                        state_d = STREAM;
                        step_d  = 4'd0;
                    end
                end else if (wc_ready) begin
                    wc_start = 1'b1;
                    step_d   = 4'd1;
                end
            end
            STREAM: begin
                if (last_q) begin
                    if (wc_done) state_d = DONE;
                end else if (wc_ready && rdusedw != 9'd0) begin
                    wc_start = 1'b1;
                    pix_en_d = 1'b1;
                    if (pix_q == PIX_LAST) last_d = 1'b1;
                    else                   pix_d  = pix_q + 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
                pix_d   = '0;
                last_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
        // Losing panel init mid-frame abandons the frame outright.
        if (state_q != IDLE && !lcd_init_done) begin
            state_d  = IDLE;
            step_d   = 4'd0;
            pix_d    = '0;
            last_d   = 1'b0;
            pix_en_d = 1'b0;
            wc_start = 1'b0;
            wc_clr   = 1'b1;
        end
        cs_n_d = !(state_d == WIN_X || state_d == WIN_Y ||
                   state_d == GRAM  || state_d == STREAM);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            step_q   <= 4'd0;
            pix_q    <= '0;
            last_q   <= 1'b0;
            cs_n_q   <= 1'b1;
            pix_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            step_q   <= step_d;
            pix_q    <= pix_d;
            last_q   <= last_d;
            cs_n_q   <= cs_n_d;
            pix_en_q <= pix_en_d;
        end
    end

    mlcd_wr_cycle #(
        .WR_LO (WR_LO),
        .WR_HI (WR_HI)
    ) u_wr (
        .clk      (clk),
        .rst_n    (rst_n),
        .clr      (wc_clr),
        .start    (wc_start),
        .rs_in    (wc_word.rs),
        .data_in  (wc_word.data),
        .wr_n     (mlcd_wr_n),
        .rs_out   (mlcd_rs),
        .data_out (mlcd_data),
        .ready    (wc_ready),
        .done     (wc_done)
    );

    assign pixel_en   = pix_en_q;
    assign mlcd_cs_n  = cs_n_q;
    assign mlcd_rd_n  = 1'b1;
    assign busy       = (state_q != IDLE);
    assign frame_done = (state_q == DONE);

endmodule
